// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_e : fetch FSM encoding
//   XLEN_DEF      : default address/PC width
//   ILEN_DEF      : default instruction width
//   RESET_PC_DEF  : default first fetch address after reset
//   PC_STEP       : byte distance between sequential instruction words
package instruction_fetch_pkg;

  localparam int          XLEN_DEF     = 64;
  localparam int          ILEN_DEF     = 32;
  localparam logic [63:0] RESET_PC_DEF = 64'h0;
  localparam int          PC_STEP      = 4;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_fifo.sv
// Fetch buffer: DEPTH x WIDTH FIFO holding {pc, instr} pairs for decode.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous clear; wins over push/pop
//   push       : write push_data at the tail
//   push_data  : entry to write
//   pop        : consume the head entry
//   head_data  : head entry, all zeros while empty
//   count      : number of occupied entries
module instruction_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 96
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C  = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push   = push && (count != FULL_C);
  assign do_pop    = pop && (count != '0);
  assign head_data = (count != '0) ? mem[rd_ptr] : '0;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the fetch PC, issues one word request at a time to
// instruction memory, buffers {pc, instr} pairs and presents them to decode.
// A redirect from execute (taken branch/jump) reloads the PC and flushes
// both the buffer and any in-flight response.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   redirect_valid/pc : execute redirect and its target (low 2 bits ignored)
//   imem_req_*        : request handshake, word-aligned address
//   imem_resp_*       : in-order response, one per accepted request
//   if_valid/ready    : buffer head handshake toward decode
//   if_pc, if_instr   : head entry, zero while the buffer is empty
//
// state      | meaning
// FETCH_REQ  | may issue a request when the buffer has room
// FETCH_WAIT | one request outstanding, response will be buffered
// FETCH_DROP | one request outstanding, response belongs to a flushed path
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              ILEN     = ILEN_DEF,
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [ILEN-1:0] if_instr
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e          state;
  fetch_state_e          state_next;
  logic [XLEN-1:0]       fetch_pc;
  logic [XLEN-1:0]       fetch_pc_next;
  logic [XLEN-1:0]       req_pc;
  logic [XLEN-1:0]       req_pc_next;
  logic [XLEN-1:0]       pc_plus4;
  logic [XLEN-1:0]       redirect_target;
  logic                  running;
  logic                  credit;
  logic                  push;
  logic                  pop;
  logic [CW-1:0]         count;
  logic [XLEN+ILEN-1:0]  head_data;

  assign pc_plus4        = fetch_pc + XLEN'(PC_STEP);
  assign redirect_target = redirect_pc & ~XLEN'(3);
  assign credit          = count < CW'(DEPTH);
  assign imem_req_addr   = fetch_pc;
  assign if_valid        = (count != '0);
  assign pop             = if_valid && if_ready;
  assign {if_pc, if_instr} = head_data;

  // Holds off the first request until the first clock after reset release,
  // so imem_req_valid is low throughout reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) running <= 1'b0;
    else        running <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH_REQ;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      req_pc   <= req_pc_next;
    end
  end

  always_comb begin
    state_next     = state;
    fetch_pc_next  = fetch_pc;
    req_pc_next    = req_pc;
    imem_req_valid = 1'b0;
    push           = 1'b0;
    case (state)
      FETCH_REQ: begin
        imem_req_valid = running && credit && !redirect_valid;
        if (imem_req_valid && imem_req_ready) begin
          req_pc_next   = fetch_pc;
          fetch_pc_next = pc_plus4;
          state_next    = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (imem_resp_valid) begin
          push       = !redirect_valid;
          state_next = FETCH_REQ;
        end else if (redirect_valid) begin
          state_next = FETCH_DROP;
        end
      end
      FETCH_DROP: begin
        // The outstanding response retires the drop even if another redirect
        // lands in the same cycle; the new PC is still taken below.
        if (imem_resp_valid) state_next = FETCH_REQ;
      end
      default: state_next = FETCH_REQ;
    endcase
    if (redirect_valid) fetch_pc_next = redirect_target;
  end

  instruction_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN + ILEN)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({req_pc, imem_resp_data}),
    .pop       (pop),
    .head_data (head_data),
    .count     (count)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic        if_ready;
  logic [63:0] if_pc;
  logic [31:0] if_instr;

  logic        w_redirect_valid = 1'b0;
  logic [63:0] w_redirect_pc = 64'h0;
  logic        w_req_valid;
  logic        w_req_ready = 1'b1;
  logic [63:0] w_req_addr;
  logic        w_resp_valid;
  logic [31:0] w_resp_data;
  logic        w_if_valid;
  logic        w_if_ready = 1'b1;
  logic [63:0] w_if_pc;
  logic [31:0] w_if_instr;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_addr_q[$];
  logic [95:0] exp_pair_q[$];

  int          grants = 0;
  int          resp_delay = 1;
  int          accepts = 0;
  int          resps = 0;
  int          redir_at = -1;
  logic [63:0] redir_target = 64'h0;
  logic        redirect_by_model = 1'b0;

  logic [63:0] w_addr_q[$];
  logic [63:0] w_first_pc = 64'h0;
  logic [31:0] w_first_instr = 32'h0;
  logic        w_seen_pc = 1'b0;

  always #5 clk = ~clk;

  instruction_fetch u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_pc           (if_pc),
    .if_instr        (if_instr)
  );

  instruction_fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (w_redirect_valid),
    .redirect_pc     (w_redirect_pc),
    .imem_req_valid  (w_req_valid),
    .imem_req_ready  (w_req_ready),
    .imem_req_addr   (w_req_addr),
    .imem_resp_valid (w_resp_valid),
    .imem_resp_data  (w_resp_data),
    .if_valid        (w_if_valid),
    .if_ready        (w_if_ready),
    .if_pc           (w_if_pc),
    .if_instr        (w_if_instr)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_accepts(input int target, input string name);
    int n = 0;
    while (accepts < target && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (accepts < target) begin
      errors++;
      $display("FAIL %s: timeout, accepts %0d required %0d", name, accepts, target);
    end
  endtask

  task automatic wait_idle(input int target, input string name);
    int n = 0;
    while ((accepts < target || exp_pair_q.size() != 0 || exp_addr_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s: timeout, accepts %0d required %0d, %0d outputs outstanding",
               name, accepts, target, exp_pair_q.size());
    end
  endtask

  // Instruction memory model for the main instance: accepts `grants` requests,
  // answers each after `resp_delay` cycles, optionally raises a redirect in
  // the same cycle as response number `redir_at`.
  initial begin
    logic        hs;
    logic        pend;
    int          cnt;
    logic [63:0] acc_addr;
    logic [63:0] paddr;
    pend = 1'b0; cnt = 0; acc_addr = '0; paddr = '0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    forever begin
      @(negedge clk);
      hs = rst_n && imem_req_valid && imem_req_ready;
      if (hs) begin
        acc_addr = imem_req_addr;
        if (exp_addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL req_addr: unexpected request to %h, none required", imem_req_addr);
        end else begin
          check("req_addr", imem_req_addr, exp_addr_q.pop_front());
        end
      end
      @(posedge clk);
      #1;
      imem_resp_valid = 1'b0;
      if (redirect_by_model) begin
        redirect_valid    = 1'b0;
        redirect_by_model = 1'b0;
      end
      if (hs) begin
        pend = 1'b1; cnt = resp_delay; paddr = acc_addr;
        accepts++; grants--;
      end
      if (pend) begin
        cnt--;
        if (cnt <= 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = mem_word(paddr);
          pend = 1'b0;
          resps++;
          if (resps == redir_at) begin
            redirect_valid    = 1'b1;
            redirect_pc       = redir_target;
            redirect_by_model = 1'b1;
          end
        end
      end
      imem_req_ready = (grants > 0);
    end
  end

  // Always-ready memory for the wrap instance; records its first two request
  // addresses and first delivered entry.
  initial begin
    logic        hs;
    logic [63:0] a;
    w_resp_valid = 1'b0; w_resp_data = '0;
    forever begin
      @(negedge clk);
      hs = rst_n && w_req_valid && w_req_ready;
      a  = w_req_addr;
      if (hs && w_addr_q.size() < 2) w_addr_q.push_back(a);
      if (rst_n && w_if_valid && !w_seen_pc) begin
        w_first_pc    = w_if_pc;
        w_first_instr = w_if_instr;
        w_seen_pc     = 1'b1;
      end
      @(posedge clk);
      #1;
      w_resp_valid = hs;
      w_resp_data  = mem_word(a);
    end
  end

  // Monitor: every entry decode consumes must be the next expected pair.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && if_valid && if_ready) begin
        if (exp_pair_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL if_out: unexpected pc=%h instr=%h, none required", if_pc, if_instr);
        end else begin
          check("if_out", {if_pc, if_instr}, exp_pair_q.pop_front());
        end
      end else if (rst_n && !if_valid) begin
        check("if_empty_zero", {if_pc, if_instr}, 96'h0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b1;
    repeat (3) tick();
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_if_valid", if_valid, 1'b0);
    check("rst_if_pc", if_pc, 64'h0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_req_addr", imem_req_addr, 64'h0);
    rst_n = 1'b1;
    check("no_req_before_clock", imem_req_valid, 1'b0);
    tick();
    check("first_req_valid", imem_req_valid, 1'b1);

    // 1: sequential fetch with 1-cycle responses
    exp_addr_q.push_back(64'h0);
    exp_addr_q.push_back(64'h4);
    exp_addr_q.push_back(64'h8);
    exp_pair_q.push_back({64'h0, 32'h1357_9BDF});
    exp_pair_q.push_back({64'h4, 32'h1357_9BDB});
    exp_pair_q.push_back({64'h8, 32'h1357_9BD7});
    grants = 3;
    wait_idle(3, "seq_fetch");

    // 2: decode stalled -> buffer fills to DEPTH and requests stop
    tick();
    if_ready = 1'b0;
    exp_addr_q.push_back(64'hC);
    exp_addr_q.push_back(64'h10);
    exp_pair_q.push_back({64'hC,  32'h1357_9BD3});
    exp_pair_q.push_back({64'h10, 32'h1357_9BCF});
    grants = 3;
    repeat (10) tick();
    check("full_accepts", accepts, 5);
    check("full_req_valid", imem_req_valid, 1'b0);
    check("full_if_valid", if_valid, 1'b1);
    check("full_head_pc", if_pc, 64'hC);
    exp_addr_q.push_back(64'h14);
    exp_pair_q.push_back({64'h14, 32'h1357_9BCB});
    if_ready = 1'b1;
    wait_idle(6, "full_drain");

    // 3: redirect while waiting; stale response dropped
    tick();
    exp_addr_q.push_back(64'h18);
    resp_delay = 3;
    grants = 1;
    wait_accepts(7, "wait_accept");
    redirect_valid = 1'b1;
    redirect_pc    = 64'h1002;
    tick();
    redirect_valid = 1'b0;
    check("drop_addr", imem_req_addr, 64'h1000);
    check("drop_req_valid", imem_req_valid, 1'b0);
    resp_delay = 1;
    exp_addr_q.push_back(64'h1000);
    exp_pair_q.push_back({64'h1000, 32'h1357_8BDF});
    grants = 1;
    wait_idle(8, "after_drop");

    // 4: redirect coincides with a response while the buffer holds an entry
    tick();
    if_ready = 1'b0;
    exp_addr_q.push_back(64'h1004);
    exp_addr_q.push_back(64'h1008);
    redir_target = 64'h2000;
    redir_at     = resps + 2;
    grants = 2;
    begin
      int n = 0;
      while (!redirect_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("redir_seen", redirect_valid, 1'b1);
    end
    check("pre_flush_if_valid", if_valid, 1'b1);
    check("pre_flush_if_pc", if_pc, 64'h1004);
    @(negedge clk);
    check("flush_if_valid", if_valid, 1'b0);
    check("flush_req_addr", imem_req_addr, 64'h2000);
    check("flush_req_valid", imem_req_valid, 1'b1);
    redir_at = -1;
    tick();
    exp_addr_q.push_back(64'h2000);
    exp_pair_q.push_back({64'h2000, 32'h1357_BBDF});
    if_ready = 1'b1;
    grants = 1;
    wait_idle(11, "after_flush");

    // 6: reset while waiting; late response ignored
    tick();
    exp_addr_q.push_back(64'h2004);
    resp_delay = 3;
    grants = 1;
    wait_accepts(12, "reset_accept");
    rst_n = 1'b0;
    #1;
    check("midrst_req_valid", imem_req_valid, 1'b0);
    check("midrst_req_addr", imem_req_addr, 64'h0);
    check("midrst_if_valid", if_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();
    check("stale_if_valid", if_valid, 1'b0);
    check("stale_req_addr", imem_req_addr, 64'h0);
    resp_delay = 1;
    exp_addr_q.push_back(64'h0);
    exp_pair_q.push_back({64'h0, 32'h1357_9BDF});
    grants = 1;
    wait_idle(13, "after_reset");

    // 5: PC wrap on the instance starting at the top of the address space
    check("wrap_count", w_addr_q.size(), 2);
    if (w_addr_q.size() == 2) begin
      check("wrap_addr0", w_addr_q[0], 64'hFFFF_FFFF_FFFF_FFFC);
      check("wrap_addr1", w_addr_q[1], 64'h0);
    end
    check("wrap_first_pc", w_first_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_first_instr", w_first_instr, 32'hECA8_6423);

    check("exp_queue_empty", exp_pair_q.size() + exp_addr_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
